hdmi_pixel_fifo: RTL and testbench

//  Upstream feeder for the 640x480 TMDS serialiser. Buffers pixels from a producer
//  (pattern generator, memory reader) and presents them to the serialiser when it

---
 rtl/hdmi_pixel_fifo_pkg.sv | 20 ++
 rtl/hdmi_pixel_fifo_mem.sv | 27 ++
 rtl/hdmi_pixel_fifo.sv | 157 +++++++++++++++
 tb/tb_hdmi_pixel_fifo.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pixel_fifo_pkg.sv
// Shared definitions for the HDMI pixel FIFO: pixel width, default blank colour,
// FSM state encoding and the stored FIFO entry layout.
package hdmi_pixel_fifo_pkg;

  localparam int unsigned PIX_W = 24;
  localparam logic [PIX_W-1:0] BLACK_RGB_DEF = 24'h000000;

  typedef enum logic {
    ST_RESYNC = 1'b0,
    ST_RUN    = 1'b1
  } state_e;

  typedef struct packed {
    logic       sof;
    logic [7:0] red;
    logic [7:0] grn;
    logic [7:0] blu;
  } pix_entry_t;

endpackage

// File: rtl/hdmi_pixel_fifo_mem.sv
// Single-clock dual-port pixel storage with an asynchronous read port, so the
// FIFO head is visible the cycle after it is written.
module hdmi_pixel_fifo_mem
  import hdmi_pixel_fifo_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  pix_entry_t        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output pix_entry_t        rd_data
);

  pix_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/hdmi_pixel_fifo.sv
// Frame-aligned show-ahead pixel FIFO feeding the TMDS serialiser.
// Optional HDMI_PIXFIFO_STATS_EN adds o_underrun_cnt and o_level.
module hdmi_pixel_fifo
  import hdmi_pixel_fifo_pkg::*;
#(
  parameter int unsigned      DEPTH     = 1024,
  parameter logic [PIX_W-1:0] BLACK_RGB = BLACK_RGB_DEF
) (
  input  logic                   i_pixclk,
  input  logic                   i_reset,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_sof,
  input  logic [7:0]             i_red,
  input  logic [7:0]             i_grn,
  input  logic [7:0]             i_blu,
  input  logic                   i_rd,
  input  logic                   i_newframe,
  output logic [7:0]             o_red,
  output logic [7:0]             o_grn,
  output logic [7:0]             o_blu,
  output logic                   o_synced,
`ifdef HDMI_PIXFIFO_STATS_EN
  output logic [15:0]            o_underrun_cnt,
  output logic [$clog2(DEPTH):0] o_level,
`endif
  output logic                   o_underflow
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              first_pending_q, first_pending_d;
  logic              ready_q, ready_d;
  logic              underflow_q, underflow_d;

  pix_entry_t head;
  pix_entry_t wr_entry;
  logic       empty;
  logic       push;
  logic       pop;
  logic       fault;

  assign empty    = (count_q == '0);
  assign push     = i_valid & ready_q;
  assign wr_entry = '{sof: i_sof, red: i_red, grn: i_grn, blu: i_blu};

  hdmi_pixel_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (i_pixclk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_q),
    .rd_data (head)
  );

  // Alignment FSM: RESYNC drops entries until an SOF head meets a frame boundary.
  always_comb begin
    state_d         = state_q;
    first_pending_d = first_pending_q;
    pop             = 1'b0;
    fault           = 1'b0;
    case (state_q)
      ST_RESYNC: begin
        if (!empty) begin
          if (!head.sof) begin
            pop = 1'b1;
          end else if (i_newframe) begin
            state_d         = ST_RUN;
            first_pending_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (i_rd) begin
          // An SOF head reached without a pending frame start means the frame was short.
          if (empty || (head.sof && !first_pending_q)) begin
            fault   = 1'b1;
            state_d = ST_RESYNC;
          end else begin
            pop             = 1'b1;
            first_pending_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_RESYNC;
      end
    endcase
  end

  // Pointer, occupancy and flag updates.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + ADDR_W'(push);
    rd_ptr_d    = rd_ptr_q + ADDR_W'(pop);
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    ready_d     = (count_d != CNT_W'(DEPTH));
    underflow_d = underflow_q | fault;
  end

  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      state_q         <= ST_RESYNC;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      first_pending_q <= 1'b0;
      ready_q         <= 1'b0;
      underflow_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      first_pending_q <= first_pending_d;
      ready_q         <= ready_d;
      underflow_q     <= underflow_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_synced    = (state_q == ST_RUN);
  assign o_underflow = underflow_q;
  assign {o_red, o_grn, o_blu} = (o_synced && !empty) ? {head.red, head.grn, head.blu}
                                                      : BLACK_RGB;

`ifdef HDMI_PIXFIFO_STATS_EN
  logic [15:0] underrun_cnt_q, underrun_cnt_d;

  // Saturating count of underflow and misalignment events.
  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    if (fault && (underrun_cnt_q != 16'hFFFF)) begin
      underrun_cnt_d = underrun_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      underrun_cnt_q <= '0;
    end else begin
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign o_underrun_cnt = underrun_cnt_q;
  assign o_level        = count_q;
`endif

endmodule

// File: tb/tb_hdmi_pixel_fifo.sv
// Directed self-checking bench for hdmi_pixel_fifo (frames are shortened to keep run time small).
module tb_hdmi_pixel_fifo;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid, i_sof, i_rd, i_newframe;
  logic [7:0] i_red, i_grn, i_blu;
  logic       o_ready, o_synced, o_underflow;
  logic [7:0] o_red, o_grn, o_blu;
`ifdef HDMI_PIXFIFO_STATS_EN
  logic [15:0]   o_underrun_cnt;
  logic [LW-1:0] o_level;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  hdmi_pixel_fifo #(.DEPTH(DEPTH)) dut (
    .i_pixclk       (clk),
    .i_reset        (rst),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_sof          (i_sof),
    .i_red          (i_red),
    .i_grn          (i_grn),
    .i_blu          (i_blu),
    .i_rd           (i_rd),
    .i_newframe     (i_newframe),
    .o_red          (o_red),
    .o_grn          (o_grn),
    .o_blu          (o_blu),
    .o_synced       (o_synced),
`ifdef HDMI_PIXFIFO_STATS_EN
    .o_underrun_cnt (o_underrun_cnt),
    .o_level        (o_level),
`endif
    .o_underflow    (o_underflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rgb_out();
    return {8'h00, o_red, o_grn, o_blu};
  endfunction

  task automatic drive_px(input logic v, input logic sof, input logic [23:0] rgb);
    i_valid = v;
    i_sof   = sof;
    {i_red, i_grn, i_blu} = rgb;
  endtask

  // Push n pixels base+i, SOF on the first one when sof_first is set.
  task automatic push_seq(input logic [23:0] base, input int n, input logic sof_first);
    for (int i = 0; i < n; i++) begin
      drive_px(1'b1, sof_first && (i == 0), base + 24'(i));
      tick();
    end
    drive_px(1'b0, 1'b0, 24'h0);
  endtask

  // Request n pixels back to back, expecting base+first+i.
  task automatic read_seq(input string tag, input logic [23:0] base, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      i_rd = 1'b1;
      check_eq(tag, rgb_out(), {8'h00, base + 24'(first + i)});
      tick();
    end
    i_rd = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    rst = 1'b1;
    i_rd = 1'b0;
    i_newframe = 1'b0;
    drive_px(1'b0, 1'b0, 24'h0);

    // Reset state
    tick();
    check_eq("reset_ready", 32'(o_ready), 32'd0);
    check_eq("reset_synced", 32'(o_synced), 32'd0);
    check_eq("reset_underflow", 32'(o_underflow), 32'd0);
    check_eq("reset_rgb", rgb_out(), 32'h0);
    rst = 1'b0;
    tick();
    check_eq("ready_after_reset", 32'(o_ready), 32'd1);

    // Normal frame, serialiser requests with blanking gaps
    push_seq(24'hA00000, 32, 1'b1);
    check_eq("t1_resync_synced", 32'(o_synced), 32'd0);
    check_eq("t1_resync_rgb", rgb_out(), 32'h0);
    i_newframe = 1'b1;
    tick();
    i_newframe = 1'b0;
    check_eq("t1_run_synced", 32'(o_synced), 32'd1);
    check_eq("t1_first_px", rgb_out(), 32'h00A00000);
    idx = 0;
    for (int cyc = 0; cyc < 200 && idx < 32; cyc++) begin
      i_rd = ((cyc % 3) != 2);
      if (i_rd) begin
        check_eq("t1_px", rgb_out(), {8'h00, 24'hA00000 + 24'(idx)});
        idx++;
      end
      tick();
    end
    i_rd = 1'b0;
    check_eq("t1_all_read", 32'(idx), 32'd32);
    check_eq("t1_empty_rgb", rgb_out(), 32'h0);
    check_eq("t1_underflow", 32'(o_underflow), 32'd0);
    check_eq("t1_still_synced", 32'(o_synced), 32'd1);

    // Underflow: request with the FIFO empty
    i_rd = 1'b1;
    check_eq("t3_black_on_empty", rgb_out(), 32'h0);
    tick();
    i_rd = 1'b0;
    check_eq("t3_underflow", 32'(o_underflow), 32'd1);
    check_eq("t3_resync", 32'(o_synced), 32'd0);
`ifdef HDMI_PIXFIFO_STATS_EN
    check_eq("t3_cnt", 32'(o_underrun_cnt), 32'd1);
`endif

    // Misalignment: short frame A followed by frame B
    push_seq(24'hB00000, 3, 1'b1);
    push_seq(24'hC00000, 4, 1'b1);
    i_newframe = 1'b1;
    tick();
    i_newframe = 1'b0;
    check_eq("t4_run", 32'(o_synced), 32'd1);
    read_seq("t4_frame_a", 24'hB00000, 0, 3);
    i_rd = 1'b1;
    check_eq("t4_sof_head", rgb_out(), 32'h00C00000);
    tick();
    i_rd = 1'b0;
    check_eq("t4_resync", 32'(o_synced), 32'd0);
    check_eq("t4_underflow", 32'(o_underflow), 32'd1);
`ifdef HDMI_PIXFIFO_STATS_EN
    check_eq("t4_cnt", 32'(o_underrun_cnt), 32'd2);
`endif
    tick();
    check_eq("t4_hold_resync", 32'(o_synced), 32'd0);
    i_newframe = 1'b1;
    tick();
    i_newframe = 1'b0;
    check_eq("t4_rerun", 32'(o_synced), 32'd1);
    read_seq("t4_frame_b", 24'hC00000, 0, 4);

    // Reset mid-frame
    push_seq(24'hD00000, 4, 1'b1);
    check_eq("t6_pre_synced", 32'(o_synced), 32'd1);
    check_eq("t6_pre_rgb", rgb_out(), 32'h00D00000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t6_ready", 32'(o_ready), 32'd0);
    check_eq("t6_synced", 32'(o_synced), 32'd0);
    check_eq("t6_underflow", 32'(o_underflow), 32'd0);
    check_eq("t6_rgb", rgb_out(), 32'h0);
`ifdef HDMI_PIXFIFO_STATS_EN
    check_eq("t6_cnt", 32'(o_underrun_cnt), 32'd0);
    check_eq("t6_level", 32'(o_level), 32'd0);
`endif
    tick();
    check_eq("t6_ready_after", 32'(o_ready), 32'd1);

    // Resync discard: 5 stray pixels then a frame; i_rd is ignored meanwhile
    i_rd = 1'b1;
    push_seq(24'h0F0000, 5, 1'b0);
    push_seq(24'h600000, 8, 1'b1);
    i_rd = 1'b0;
    check_eq("t2_synced", 32'(o_synced), 32'd0);
    check_eq("t2_rgb", rgb_out(), 32'h0);
`ifdef HDMI_PIXFIFO_STATS_EN
    check_eq("t2_level", 32'(o_level), 32'd8);
`endif
    i_newframe = 1'b1;
    tick();
    i_newframe = 1'b0;
    check_eq("t2_run", 32'(o_synced), 32'd1);
    read_seq("t2_frame", 24'h600000, 0, 8);
    check_eq("t2_underflow", 32'(o_underflow), 32'd0);

    // Full FIFO handling and ordering across pointer wrap
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    push_seq(24'h500000, DEPTH, 1'b1);
    check_eq("t5_full_ready", 32'(o_ready), 32'd0);
`ifdef HDMI_PIXFIFO_STATS_EN
    check_eq("t5_full_level", 32'(o_level), DEPTH);
`endif
    drive_px(1'b1, 1'b0, 24'h500000 + 24'(DEPTH));
    i_newframe = 1'b1;
    tick();
    i_newframe = 1'b0;
    check_eq("t5_run", 32'(o_synced), 32'd1);
    check_eq("t5_head0", rgb_out(), 32'h00500000);
    check_eq("t5_blocked", 32'(o_ready), 32'd0);
    i_rd = 1'b1;
    tick();
    check_eq("t5_ready_after_pop", 32'(o_ready), 32'd1);
    check_eq("t5_head1", rgb_out(), 32'h00500001);
    tick();
    check_eq("t5_head2", rgb_out(), 32'h00500002);
    check_eq("t5_ready_pushpop", 32'(o_ready), 32'd1);
`ifdef HDMI_PIXFIFO_STATS_EN
    check_eq("t5_level_pushpop", 32'(o_level), DEPTH - 1);
`endif
    i_rd = 1'b0;
    drive_px(1'b1, 1'b0, 24'h500000 + 24'(DEPTH + 1));
    tick();
    drive_px(1'b0, 1'b0, 24'h0);
    check_eq("t5_refull_ready", 32'(o_ready), 32'd0);
`ifdef HDMI_PIXFIFO_STATS_EN
    check_eq("t5_refull_level", 32'(o_level), DEPTH);
`endif
    read_seq("t5_drain", 24'h500000, 2, DEPTH);
    check_eq("t5_empty_rgb", rgb_out(), 32'h0);
    check_eq("t5_underflow", 32'(o_underflow), 32'd0);
    check_eq("t5_ready_end", 32'(o_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
